// File: rtl/aes128_decrypt_iter.sv
// aes128_decrypt_iter - iterative AES-128 decryptor (FIPS-197 inverse cipher).
//
// Takes one ciphertext block and the cipher key (round key 0). It first expands
// the key forward to round key 10. It then runs the inverse rounds, one per
// clock, and walks the key schedule backwards as it goes.
// Byte 0 of the state, key and output sits in bits [127:120] (column-major).
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low
//   start      job request, sampled only while busy==0
//   ciphertext block to decrypt, captured on accepted start
//   key        cipher key, captured on accepted start
//   plaintext  result, registered, held until the next done
//   done       one-cycle pulse, plaintext valid
//   busy       high from the cycle after accept through the cycle before done
//
// Parameter KEY_CACHE=1 keeps the last key/round-key-10 pair. A job with the
// same key then skips the 10-cycle forward expansion.

module aes_sbox #(
    parameter bit INV = 1'b0
) (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] acc, t;
        acc = '0;
        t   = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) acc = acc ^ t;
            t = xt(t);
        end
        return acc;
    endfunction

    // Multiplicative inverse as v^254. The result for 0 is 0, which the S-box needs.
    function automatic logic [7:0] ginv(input logic [7:0] v);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gmul(v, v);
        x3   = gmul(x2, v);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        return gmul(gmul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] fwd_aff(input logic [7:0] b);
        return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_aff(input logic [7:0] s);
        return rl(s, 1) ^ rl(s, 3) ^ rl(s, 6) ^ 8'h05;
    endfunction

    assign y = INV ? ginv(inv_aff(a)) : fwd_aff(ginv(a));
endmodule

module aes128_decrypt_iter #(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic [127:0] plaintext,
    output logic         done,
    output logic         busy
);
    typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL} fsm_t;

    fsm_t         fsm;
    logic [3:0]   rnd;
    logic [127:0] st;       // cipher state, loaded with the ciphertext on accept
    logic [127:0] wkey;     // working round key
    logic [127:0] key_q;    // key of the most recent job (cache tag)
    logic [127:0] ck10;     // cached round key 10 for key_q
    logic         ck_vld;

    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // One column of InvMixColumns. Row i uses coefficients 0e,0b,0d,09 starting at byte i.
    function automatic logic [31:0] inv_mix(input logic [31:0] c);
        logic [7:0] a[4], x2[4], x4[4], x8[4], y[4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2[i] = xt(a[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
        end
        for (int i = 0; i < 4; i++)
            y[i] = (x8[i] ^ x4[i] ^ x2[i])
                 ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                 ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                 ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
        return {y[0], y[1], y[2], y[3]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0: return 8'h01;
            4'd1: return 8'h02;
            4'd2: return 8'h04;
            4'd3: return 8'h08;
            4'd4: return 8'h10;
            4'd5: return 8'h20;
            4'd6: return 8'h40;
            4'd7: return 8'h80;
            4'd8: return 8'h1b;
            4'd9: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- data path: InvShiftRows folded into the S-box wiring
    logic [127:0] sr_sb, ark, imc;

    for (genvar i = 0; i < 16; i++) begin : g_isb
        localparam int R   = i % 4;
        localparam int C   = i / 4;
        localparam int SRC = R + 4 * ((C + 4 - R) % 4);
        aes_sbox #(.INV(1'b1)) u_isb (.a(st[127-8*SRC -: 8]), .y(sr_sb[127-8*i -: 8]));
    end

    assign ark = sr_sb ^ wkey;

    for (genvar c = 0; c < 4; c++) begin : g_imc
        assign imc[127-32*c -: 32] = inv_mix(ark[127-32*c -: 32]);
    end

    // ---------------- key path: the forward and inverse steps share one SubWord
    logic [31:0]  w0, w1, w2, w3, sw_in, rot, sw, rcw;
    logic [3:0]   rc_idx;
    logic [127:0] kfwd, kinv;

    assign {w0, w1, w2, w3} = wkey;

    always_comb begin
        rc_idx = rnd - 4'd1;
        if (fsm == KEXP)      rc_idx = rnd;
        else if (fsm == INIT) rc_idx = 4'd9;
    end

    assign sw_in = (fsm == KEXP) ? w3 : (w3 ^ w2);
    assign rot   = {sw_in[23:0], sw_in[31:24]};
    assign rcw   = {rcon(rc_idx), 24'h0};

    for (genvar j = 0; j < 4; j++) begin : g_sw
        aes_sbox #(.INV(1'b0)) u_sb (.a(rot[31-8*j -: 8]), .y(sw[31-8*j -: 8]));
    end

    logic [31:0] f0, f1, f2;
    assign f0   = w0 ^ sw ^ rcw;
    assign f1   = w1 ^ f0;
    assign f2   = w2 ^ f1;
    assign kfwd = {f0, f1, f2, w3 ^ f2};
    assign kinv = {w0 ^ sw ^ rcw, w1 ^ w0, w2 ^ w1, w3 ^ w2};

    logic hit;
    assign hit = (KEY_CACHE != 0) && ck_vld && (key == key_q);

    // ---------------- control
    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm       <= IDLE;
            rnd       <= '0;
            st        <= '0;
            wkey      <= '0;
            key_q     <= '0;
            ck10      <= '0;
            ck_vld    <= 1'b0;
            plaintext <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        st    <= ciphertext;
                        key_q <= key;
                        busy  <= 1'b1;
                        rnd   <= '0;
                        if (hit) begin
                            wkey <= ck10;
                            fsm  <= INIT;
                        end else begin
                            wkey   <= key;
                            ck_vld <= 1'b0;
                            fsm    <= KEXP;
                        end
                    end
                end
                KEXP: begin
                    wkey <= kfwd;
                    rnd  <= rnd + 4'd1;
                    if (rnd == 4'd9) begin
                        ck10   <= kfwd;
                        ck_vld <= (KEY_CACHE != 0);
                        fsm    <= INIT;
                    end
                end
                INIT: begin
                    st   <= st ^ wkey;
                    wkey <= kinv;
                    rnd  <= 4'd9;
                    fsm  <= ROUND;
                end
                ROUND: begin
                    st   <= imc;
                    wkey <= kinv;
                    rnd  <= rnd - 4'd1;
                    if (rnd == 4'd1) fsm <= FINAL;
                end
                FINAL: begin
                    plaintext <= ark;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    rnd       <= '0;
                    fsm       <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
module tb_aes128_decrypt_iter;
    logic         clk = 1'b0;
    logic         reset, start, done, busy;
    logic [127:0] ciphertext, key, plaintext;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    aes128_decrypt_iter #(.KEY_CACHE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .ciphertext(ciphertext),
        .key(key), .plaintext(plaintext), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference AES built from table lookups
    logic [7:0] sb[256];
    logic [7:0] isb[256];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [127:0] rkey(input logic [127:0] k, input int r);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] mixcols(input logic [127:0] v, input bit inv);
        logic [7:0] m[4];
        logic [7:0] s[16];
        logic [127:0] o;
        if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc;
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gm(m[(j - row + 4) % 4], s[4*c + j]);
                o[127-8*(4*c+row) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] k);
        logic [127:0] v, o;
        v = ct ^ rkey(k, 10);
        for (int r = 9; r >= 0; r--) begin
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    o[127-8*(row + 4*((c + row) % 4)) -: 8] = isb[v[127-8*(row + 4*c) -: 8]];
            v = o ^ rkey(k, r);
            if (r > 0) v = mixcols(v, 1'b1);
        end
        return v;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] v, o;
        v = pt ^ rkey(k, 0);
        for (int r = 1; r <= 10; r++) begin
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    o[127-8*(row + 4*c) -: 8] = sb[v[127-8*(row + 4*((c + row) % 4)) -: 8]];
            if (r < 10) o = mixcols(o, 1'b0);
            v = o ^ rkey(k, r);
        end
        return v;
    endfunction

    // ---------------- cycle model: accept, fixed latency, key cache
    logic         m_busy = 1'b0, m_done = 1'b0, m_cvld = 1'b0;
    logic [127:0] m_pt = '0, m_res = '0, m_key = '0, m_ckey = '0;
    int           m_cnt = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_pt = '0; m_cnt = 0; m_cvld = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_pt = m_res;
                    m_cvld = 1'b1; m_ckey = m_key;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_cnt  = (m_cvld && key == m_ckey) ? 11 : 21;
                m_res  = aes_dec(ciphertext, key);
                m_key  = key;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_done", 128'(done), 128'(m_done));
            chk("cyc_busy", 128'(busy), 128'(m_busy));
            chk("cyc_plaintext", plaintext, m_pt);
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge with the DUT idle. Returns at the negedge of the done cycle.
    task automatic job(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] exp,
                       input int lat, input bit spam, input string nm);
        int n;
        start = 1'b1; ciphertext = ct; key = k;
        @(negedge clk);
        n = 0;
        start = spam; ciphertext = rnd128(); key = rnd128();
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (!done) begin start = spam; ciphertext = rnd128(); key = rnd128(); end
        end
        start = 1'b0;
        chk({nm, "_latency"}, 128'(n), 128'(lat));
        chk({nm, "_plaintext"}, plaintext, exp);
    endtask

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    initial begin
        logic [127:0] k, pk, pt;
        int n;
        reset = 1'b0; start = 1'b0; ciphertext = '0; key = '0;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
            sb[x] = s;
            isb[s] = 8'(x);
        end

        // Pin the reference model to the published vectors.
        chk("model_dec_A", aes_dec(CT_A, KEY_A), PT_A);
        chk("model_enc_A", aes_enc(PT_A, KEY_A), CT_A);
        chk("model_dec_B", aes_dec(CT_B, KEY_B), PT_B);
        chk("model_k10_B", rkey(KEY_B, 10), K10_B);

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_done", 128'(done), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_plaintext", plaintext, 128'(0));
        reset = 1'b1;
        @(negedge clk);

        job(CT_A, KEY_A, PT_A, 21, 1'b0, "fips_c1");
        repeat (2) @(negedge clk);
        job(CT_B, KEY_B, PT_B, 21, 1'b0, "fips_b");
        chk("fips_b_k10", dut.ck10, K10_B);
        repeat (3) @(negedge clk);
        job(CT_B, KEY_B, PT_B, 11, 1'b0, "cache_hit");
        @(negedge clk);
        job(CT_A, KEY_A, PT_A, 21, 1'b0, "cache_miss");
        @(negedge clk);

        // Starts while busy are ignored. A start in the done cycle is accepted.
        job(CT_B, KEY_B, PT_B, 21, 1'b1, "spam");
        job(CT_A, KEY_A, PT_A, 21, 1'b0, "done_cycle_start");
        @(negedge clk);

        // Reset mid-job. The later job with the same key must miss the cache.
        start = 1'b1; ciphertext = CT_B; key = KEY_B;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n < 12) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_plaintext", plaintext, 128'(0));
        reset = 1'b1;
        repeat (2) @(negedge clk);
        job(CT_B, KEY_B, PT_B, 21, 1'b0, "after_abort");
        @(negedge clk);

        // Loopback against the reference encryptor. Every fourth job reuses the previous key.
        pk = KEY_B;
        for (int i = 0; i < 1000; i++) begin
            k  = (i % 4 == 1) ? pk : rnd128();
            pt = rnd128();
            job(aes_enc(pt, k), k, pt, (i % 4 == 1) ? 11 : 21, 1'b0, "loopback");
            pk = k;
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
